// File: rtl/joy_pkg.sv
// Shared types and helpers for the joystick position integrator.
// Classification maps a latched sample to a direction and a step period.
package joy_pkg;

  typedef enum logic [1:0] {
    JOY_IDLE,
    JOY_UP,
    JOY_DOWN
  } joy_dir_e;

  typedef struct packed {
    joy_dir_e    dir;
    logic [31:0] period;
  } joy_cls_t;

  function automatic int unsigned joy_center(
    input int unsigned vw
  );
    return 32'd1 << (vw - 1);
  endfunction

  // period = CENTER - mag; mag is the distance from the centre pair
  function automatic joy_cls_t joy_classify(
    input int unsigned s,
    input int unsigned vw,
    input int unsigned dz
  );
    int unsigned c;
    int unsigned mag;
    joy_cls_t    r;
    c        = joy_center(vw);
    r.dir    = JOY_IDLE;
    r.period = '0;
    if (s < c - dz) begin
      mag      = c - s;
      r.dir    = JOY_DOWN;
      r.period = c - mag;
    end else if (s > c - 1 + dz) begin
      mag      = s - (c - 1);
      r.dir    = JOY_UP;
      r.period = c - mag;
    end
    return r;
  endfunction

endpackage

// File: rtl/joy_pos_integrator_if.sv
// Sample/home inputs and per-axis position/flag outputs.
interface joy_pos_integrator_if #(
  parameter int unsigned N_AXES = 2,
  parameter int unsigned VW     = 8,
  parameter int unsigned PW     = 8
);
  logic [N_AXES*VW-1:0] sample_i;
  logic                 sample_valid_i;
  logic                 home_i;
  logic [N_AXES*PW-1:0] pos_o;
  logic [N_AXES-1:0]    step_o;
  logic [N_AXES-1:0]    dir_o;
  logic [N_AXES-1:0]    at_limit_o;

  modport master (
    output sample_i, sample_valid_i, home_i,
    input  pos_o, step_o, dir_o, at_limit_o
  );

  modport slave (
    input  sample_i, sample_valid_i, home_i,
    output pos_o, step_o, dir_o, at_limit_o
  );
endinterface

// File: rtl/joy_axis_stepper.sv
// One axis: sample latch, rate counter, bounded position and flags.
// JOY_POS_WRAP_EN: position wraps and at_limit_o pulses on wrap.
module joy_axis_stepper
  import joy_pkg::*;
#(
  parameter int unsigned VW       = 8,
  parameter int unsigned PW       = 8,
  parameter int unsigned DEADZONE = 4,
  parameter int unsigned HOME_POS = 128
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          tick_i,
  input  logic [VW-1:0] sample_i,
  input  logic          sample_valid_i,
  input  logic          home_i,
  output logic [PW-1:0] pos_o,
  output logic          step_o,
  output logic          dir_o,
  output logic          at_limit_o
);
  localparam logic [VW-1:0] CENTER = VW'(joy_center(VW));
  localparam logic [PW-1:0] HOME   = PW'(HOME_POS);
  localparam logic [PW-1:0] PMAX   = '1;

  logic [VW-1:0] lat_q, lat_d;
  logic [VW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pos_q, pos_d;
  logic          step_q, step_d;
  logic          dir_q, dir_d;
  logic          lim_q, lim_d;
  logic          wrap;
  joy_cls_t      cls;

  always_comb begin
    cls    = joy_classify(32'(lat_q), VW, DEADZONE);
    lat_d  = sample_valid_i ? sample_i : lat_q;
    cnt_d  = cnt_q;
    pos_d  = pos_q;
    step_d = 1'b0;
    wrap   = 1'b0;
    if (home_i) begin
      pos_d = HOME;
      cnt_d = '0;
    end else if (tick_i) begin
      if (cls.dir == JOY_IDLE) begin
        cnt_d = '0;
      end else if (32'(cnt_q) < cls.period) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        cnt_d = '0;
        if (cls.dir == JOY_DOWN) begin
          wrap  = (pos_q == '0);
          pos_d = pos_q - 1'b1;
        end else begin
          wrap  = (pos_q == PMAX);
          pos_d = pos_q + 1'b1;
        end
`ifndef JOY_POS_WRAP_EN
        if (wrap) pos_d = pos_q;
`endif
        step_d = (pos_d != pos_q);
      end
    end
    dir_d = (cls.dir == JOY_DOWN);
`ifdef JOY_POS_WRAP_EN
    lim_d = wrap & step_d;
`else
    lim_d = (cls.dir == JOY_DOWN && pos_d == '0)
         || (cls.dir == JOY_UP && pos_d == PMAX);
`endif
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      lat_q  <= CENTER;
      cnt_q  <= '0;
      pos_q  <= HOME;
      step_q <= 1'b0;
      dir_q  <= 1'b0;
      lim_q  <= 1'b0;
    end else begin
      lat_q  <= lat_d;
      cnt_q  <= cnt_d;
      pos_q  <= pos_d;
      step_q <= step_d;
      dir_q  <= dir_d;
      lim_q  <= lim_d;
    end
  end

  assign pos_o      = pos_q;
  assign step_o     = step_q;
  assign dir_o      = dir_q;
  assign at_limit_o = lim_q;
endmodule

// File: rtl/joy_pos_integrator.sv
// Multi-axis joystick position integrator with shared tick prescaler.
// Optional JOY_POS_WRAP_EN selects wrapping positions (see stepper).
module joy_pos_integrator #(
  parameter int unsigned N_AXES   = 2,
  parameter int unsigned VW       = 8,
  parameter int unsigned PW       = 8,
  parameter int unsigned DEADZONE = 4,
  parameter int unsigned TICK_DIV = 65536,
  parameter int unsigned HOME_POS = 1 << (PW - 1)
) (
  input logic                 clk_i,
  input logic                 rst_i,
  joy_pos_integrator_if.slave bus
);
  localparam int unsigned PSW = $clog2(TICK_DIV);

  logic [PSW-1:0]       psc_q, psc_d;
  logic                 tick;
  logic [N_AXES*PW-1:0] pos_w;
  logic [N_AXES-1:0]    step_w, dir_w, lim_w;

  assign tick  = (psc_q == PSW'(TICK_DIV - 1));
  assign psc_d = tick ? '0 : psc_q + 1'b1;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) psc_q <= '0;
    else        psc_q <= psc_d;
  end

  for (genvar k = 0; k < N_AXES; k++) begin : g_axis
    joy_axis_stepper #(
      .VW       (VW),
      .PW       (PW),
      .DEADZONE (DEADZONE),
      .HOME_POS (HOME_POS)
    ) u_axis (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .tick_i         (tick),
      .sample_i       (bus.sample_i[k*VW +: VW]),
      .sample_valid_i (bus.sample_valid_i),
      .home_i         (bus.home_i),
      .pos_o          (pos_w[k*PW +: PW]),
      .step_o         (step_w[k]),
      .dir_o          (dir_w[k]),
      .at_limit_o     (lim_w[k])
    );
  end

  assign bus.pos_o      = pos_w;
  assign bus.step_o     = step_w;
  assign bus.dir_o      = dir_w;
  assign bus.at_limit_o = lim_w;
endmodule
